// File: rtl/rpn_pkg.sv
// Shared constants for the RPN token sequencer: ALU opcodes, token kinds and
// the sequencer FSM encoding.
package rpn_pkg;

  // ALU opcodes driven onto the ALU opcode pins.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  // Token kinds on tok_kind.
  localparam logic [1:0] TK_OPERAND = 2'b00;
  localparam logic [1:0] TK_ADD     = 2'b01;
  localparam logic [1:0] TK_MUL     = 2'b10;
  localparam logic [1:0] TK_END     = 2'b11;

  typedef enum logic [2:0] {
    ST_ACCEPT = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } rpn_state_e;

  // An END token becomes a POP; every other kind maps one-to-one.
  function automatic logic [2:0] tok_to_op(input logic [1:0] kind);
    logic [2:0] op;
    case (kind)
      TK_OPERAND: op = OP_PUSH;
      TK_ADD:     op = OP_ADD;
      TK_MUL:     op = OP_MUL;
      default:    op = OP_POP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rpn_token_sequencer.sv
// RPN token sequencer: turns a postfix token stream into opcode/data pulses
// for a stack ALU and returns the final value with overflow/error flags.
//
// state  | meaning
// -------+----------------------------------------------------------------
// ACCEPT | tok_ready high, waiting for a token handshake
// CHECK  | latched token checked against tracked stack depth
// ISSUE  | mapped opcode (and push data) presented to the ALU
// GAP    | opcode back to NOP; ALU outputs sampled, depth updated
// DONE   | result held on res_* until res_ready
module rpn_token_sequencer
  import rpn_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_value,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

  rpn_state_e    state_q;
  logic [1:0]    kind_q;
  logic [N-1:0]  value_q;
  logic [DW-1:0] depth_q;
  logic          ovf_q;
  logic          err_q;
  logic          tok_ready_q;
  logic [2:0]    opcode_q;
  logic [N-1:0]  data_q;
  logic          res_valid_q;
  logic [N-1:0]  res_data_q;

  logic          tok_legal;
  logic          is_arith;
  logic [DW-1:0] depth_d;
  logic [2:0]    opcode_d;
  logic [N-1:0]  data_d;

  // Legality of the latched token against the depth tracked so far.
  always_comb begin
    tok_legal = 1'b1;
    case (kind_q)
      TK_OPERAND:     tok_legal = (depth_q != DEPTH_FULL);
      TK_ADD, TK_MUL: tok_legal = (depth_q >= DEPTH_TWO);
      default:        tok_legal = (depth_q != '0);
    endcase
  end

  // Opcode/data to issue and the depth after the issued op retires.
  always_comb begin
    is_arith = (kind_q == TK_ADD) || (kind_q == TK_MUL);
    opcode_d = tok_to_op(kind_q);
    data_d   = (kind_q == TK_OPERAND) ? value_q : '0;
    depth_d  = (kind_q == TK_OPERAND) ? depth_q + DEPTH_ONE : depth_q - DEPTH_ONE;
  end

  // Sequencer FSM; every output is registered so the ALU sees clean pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      kind_q      <= TK_OPERAND;
      value_q     <= '0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      tok_ready_q <= 1'b0;
      opcode_q    <= OP_NOP;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (tok_valid && tok_ready_q) begin
            kind_q      <= tok_kind;
            value_q     <= tok_value;
            tok_ready_q <= 1'b0;
            state_q     <= ST_CHECK;
          end else begin
            tok_ready_q <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (tok_legal) begin
            opcode_q <= opcode_d;
            data_q   <= data_d;
            // An END that leaves entries behind still pops, but flags the expression.
            if (kind_q == TK_END && depth_q > DEPTH_ONE) begin
              err_q <= 1'b1;
            end
            state_q <= ST_ISSUE;
          end else if (kind_q == TK_END) begin
            // Nothing on the stack: report zero with the error flag, no POP.
            err_q       <= 1'b1;
            res_data_q  <= '0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            err_q       <= 1'b1;
            tok_ready_q <= 1'b1;
            state_q     <= ST_ACCEPT;
          end
        end
        ST_ISSUE: begin
          // Dropping to NOP guarantees an opcode edge for repeated operations.
          opcode_q <= OP_NOP;
          data_q   <= '0;
          state_q  <= ST_GAP;
        end
        ST_GAP: begin
          depth_q <= depth_d;
          if (is_arith) begin
            ovf_q <= ovf_q | alu_overflow;
          end
          if (kind_q == TK_END) begin
            res_data_q  <= alu_result;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            tok_ready_q <= 1'b1;
            state_q     <= ST_ACCEPT;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            tok_ready_q <= 1'b1;
            state_q     <= ST_ACCEPT;
          end
        end
        default: begin
          state_q <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign tok_ready    = tok_ready_q;
  assign alu_opcode   = opcode_q;
  assign alu_data     = data_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_overflow = ovf_q;
  assign res_error    = err_q;

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Bench for rpn_token_sequencer: a behavioural stack ALU answers the opcode
// pins, and an expression-level model predicts value, flags and opcode trace.
module tb_rpn_token_sequencer;
  import rpn_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } tok_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [1:0]   tok_kind = 2'b00;
  logic [N-1:0] tok_value = '0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result;
  logic         alu_overflow;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rpn_token_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_value(tok_value),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_overflow(res_overflow), .res_error(res_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stack ALU stand-in: acts on each opcode edge, outputs settle by the next cycle.
  logic [7:0] alu_stk[$];
  logic [2:0] alu_prev;
  int         alu_a, alu_b, alu_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_stk.delete();
      alu_result   <= '0;
      alu_overflow <= 1'b0;
      alu_prev     <= OP_NOP;
    end else begin
      alu_prev <= alu_opcode;
      if (alu_opcode != alu_prev) begin
        case (alu_opcode)
          OP_PUSH: alu_stk.push_back(alu_data);
          OP_ADD, OP_MUL: begin
            if (alu_stk.size() >= 2) begin
              alu_b = int'($signed(alu_stk.pop_back()));
              alu_a = int'($signed(alu_stk.pop_back()));
              alu_r = (alu_opcode == OP_ADD) ? alu_a + alu_b : alu_a * alu_b;
              alu_overflow <= (alu_r > 127) || (alu_r < -128);
              alu_stk.push_back(8'(alu_r));
              alu_result <= 8'(alu_r);
            end
          end
          OP_POP: if (alu_stk.size() > 0) alu_result <= alu_stk.pop_back();
          default: ;
        endcase
      end
    end
  end

  // Opcode trace plus protocol watchdogs (back-to-back ops, both handshakes open).
  logic [2:0] trace[$];
  int         gap_viol = 0;
  int         dual_viol = 0;
  logic [2:0] mon_prev = OP_NOP;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = OP_NOP;
    end else begin
      if (alu_opcode != OP_NOP) begin
        trace.push_back(alu_opcode);
        if (mon_prev != OP_NOP) gap_viol++;
      end
      if (tok_ready && res_valid) dual_viol++;
      mon_prev = alu_opcode;
    end
  end

  // Expression-level reference model.
  tok_t       expr_q[$];
  logic [7:0] exp_res;
  logic       exp_ovf, exp_err;
  logic [2:0] exp_ops[$];
  int         exp_lat;

  task automatic model_expr();
    int stk[$];
    int a, b, r;
    exp_res = '0; exp_ovf = 1'b0; exp_err = 1'b0; exp_lat = 3;
    exp_ops.delete();
    foreach (expr_q[i]) begin
      case (expr_q[i].kind)
        TK_OPERAND: begin
          if (stk.size() >= DEPTH) exp_err = 1'b1;
          else begin
            stk.push_back(int'($signed(expr_q[i].val)));
            exp_ops.push_back(OP_PUSH);
          end
        end
        TK_ADD, TK_MUL: begin
          if (stk.size() < 2) exp_err = 1'b1;
          else begin
            b = stk.pop_back();
            a = stk.pop_back();
            r = (expr_q[i].kind == TK_ADD) ? a + b : a * b;
            if (r > 127 || r < -128) exp_ovf = 1'b1;
            stk.push_back(int'($signed(8'(r))));
            exp_ops.push_back((expr_q[i].kind == TK_ADD) ? OP_ADD : OP_MUL);
          end
        end
        default: begin
          if (stk.size() == 0) begin
            exp_err = 1'b1; exp_res = '0; exp_lat = 1;
          end else begin
            exp_res = 8'(stk.pop_back());
            if (stk.size() > 0) exp_err = 1'b1;
            exp_ops.push_back(OP_POP);
          end
        end
      endcase
    end
  endtask

  function automatic bit trace_matches();
    if (trace.size() != exp_ops.size()) return 1'b0;
    foreach (trace[i]) if (trace[i] !== exp_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit trace_has(input logic [2:0] op);
    foreach (trace[i]) if (trace[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_tok(input logic [1:0] kind, input logic [7:0] val);
    tok_t t;
    t.kind = kind;
    t.val  = val;
    expr_q.push_back(t);
  endtask

  // Driver state captured for the scenario tasks.
  int         hs_q[$];
  int         hold_viol;
  int         obs_lat;
  logic [7:0] obs_res;
  logic       obs_ovf, obs_err, obs_after;

  task automatic send_token(input logic [1:0] kind, input logic [7:0] val);
    int k;
    @(negedge clk);
    tok_valid = 1'b1; tok_kind = kind; tok_value = val;
    k = 0;
    while (!tok_ready && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (!tok_ready) begin
      errors++;
      $display("FAIL tok_handshake_timeout tok_ready=%0b required=1", tok_ready);
    end
    hs_q.push_back(cyc);
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  task automatic run_expr(input int ready_delay);
    int k;
    trace.delete(); hs_q.delete();
    gap_viol = 0; dual_viol = 0; hold_viol = 0;
    foreach (expr_q[i]) send_token(expr_q[i].kind, expr_q[i].val);
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL res_valid_timeout res_valid=%0b required=1", res_valid);
    end
    obs_lat = cyc - hs_q[hs_q.size()-1] - 1;
    obs_res = res_data; obs_ovf = res_overflow; obs_err = res_error;
    for (int d = 0; d < ready_delay; d++) begin
      if (!res_valid || tok_ready || res_data !== obs_res ||
          res_overflow !== obs_ovf || res_error !== obs_err) hold_viol++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    obs_after = tok_ready && !res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (tok_ready !== 1'b0) begin errors++; $display("FAIL reset_tok_ready got=%0b exp=0", tok_ready); end
    checks++; if (alu_opcode !== OP_NOP) begin errors++; $display("FAIL reset_opcode got=%b exp=000", alu_opcode); end
    checks++; if (alu_data !== 8'd0 || res_data !== 8'd0) begin errors++; $display("FAIL reset_data alu_data=%0d res_data=%0d exp=0", alu_data, res_data); end
    checks++; if ({res_valid, res_overflow, res_error} !== 3'b000) begin errors++; $display("FAIL reset_res_flags got=%b exp=000", {res_valid, res_overflow, res_error}); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (tok_ready !== 1'b0) begin errors++; $display("FAIL release_tok_ready_early got=%0b exp=0", tok_ready); end
    @(posedge clk); #1;
    checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL release_tok_ready got=%0b exp=1", tok_ready); end
  endtask

  task automatic test_basic();
    expr_q.delete();
    add_tok(TK_OPERAND, 8'd3); add_tok(TK_OPERAND, 8'd4); add_tok(TK_ADD, 8'd0); add_tok(TK_END, 8'd0);
    model_expr();
    run_expr(0);
    checks++; if (obs_res !== 8'd7) begin errors++; $display("FAIL basic_res got=%0d exp=7", obs_res); end
    checks++; if (obs_ovf !== 1'b0 || obs_err !== 1'b0) begin errors++; $display("FAIL basic_flags ovf=%0b err=%0b exp=0,0", obs_ovf, obs_err); end
    checks++; if (trace.size() != 4 || trace[0] !== OP_PUSH || trace[1] !== OP_PUSH || trace[2] !== OP_ADD || trace[3] !== OP_POP)
      begin errors++; $display("FAIL basic_trace got=%p exp=PUSH,PUSH,ADD,POP", trace); end
    checks++; if (gap_viol != 0) begin errors++; $display("FAIL basic_nop_gap got=%0d exp=0", gap_viol); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (hs_q[i] - hs_q[i-1] != 4) begin errors++; $display("FAIL basic_token_period idx=%0d got=%0d exp=4", i, hs_q[i] - hs_q[i-1]); end
    end
    checks++; if (obs_lat != 3) begin errors++; $display("FAIL basic_end_latency got=%0d exp=3", obs_lat); end
    checks++; if (!obs_after) begin errors++; $display("FAIL basic_release got=%0b exp=1", obs_after); end
  endtask

  task automatic test_overflow();
    expr_q.delete();
    add_tok(TK_OPERAND, 8'd100); add_tok(TK_OPERAND, 8'd2); add_tok(TK_MUL, 8'd0); add_tok(TK_END, 8'd0);
    run_expr(1);
    checks++; if (obs_res !== 8'd200) begin errors++; $display("FAIL ovf_res got=%0d exp=200", obs_res); end
    checks++; if (obs_ovf !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL ovf_flags ovf=%0b err=%0b exp=1,0", obs_ovf, obs_err); end
  endtask

  task automatic test_underflow();
    expr_q.delete();
    add_tok(TK_OPERAND, 8'd5); add_tok(TK_ADD, 8'd0); add_tok(TK_END, 8'd0);
    model_expr();
    run_expr(0);
    checks++; if (obs_res !== 8'd5 || obs_err !== 1'b1) begin errors++; $display("FAIL underflow_res res=%0d err=%0b exp=5,1", obs_res, obs_err); end
    checks++; if (trace_has(OP_ADD)) begin errors++; $display("FAIL underflow_add_issued got=%p exp=no ADD", trace); end
    checks++; if (!trace_matches()) begin errors++; $display("FAIL underflow_trace got=%p exp=%p", trace, exp_ops); end
    checks++; if (hs_q[2] - hs_q[1] != 2) begin errors++; $display("FAIL underflow_illegal_period got=%0d exp=2", hs_q[2] - hs_q[1]); end
  endtask

  task automatic test_stack_full();
    expr_q.delete();
    for (int i = 0; i < 9; i++) add_tok(TK_OPERAND, 8'($urandom_range(0, 255)));
    add_tok(TK_END, 8'd0);
    model_expr();
    run_expr(2);
    checks++; if (obs_res !== expr_q[7].val) begin errors++; $display("FAIL full_res got=%0d exp=%0d", obs_res, expr_q[7].val); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL full_err got=%0b exp=1", obs_err); end
    checks++; if (!trace_matches()) begin errors++; $display("FAIL full_trace got=%p exp=%p", trace, exp_ops); end
  endtask

  task automatic test_empty_end();
    expr_q.delete();
    add_tok(TK_END, 8'd0);
    run_expr(0);
    checks++; if (obs_res !== 8'd0 || obs_err !== 1'b1) begin errors++; $display("FAIL empty_res res=%0d err=%0b exp=0,1", obs_res, obs_err); end
    checks++; if (trace.size() != 0) begin errors++; $display("FAIL empty_trace got=%p exp=none", trace); end
    checks++; if (obs_lat != 1) begin errors++; $display("FAIL empty_latency got=%0d exp=1", obs_lat); end
  endtask

  task automatic test_backpressure();
    expr_q.delete();
    add_tok(TK_OPERAND, 8'd1); add_tok(TK_OPERAND, 8'd2); add_tok(TK_ADD, 8'd0); add_tok(TK_END, 8'd0);
    run_expr(5);
    checks++; if (obs_res !== 8'd3) begin errors++; $display("FAIL bp_res got=%0d exp=3", obs_res); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    checks++; if (!obs_after) begin errors++; $display("FAIL bp_release got=%0b exp=1", obs_after); end
    checks++; if (dual_viol != 0) begin errors++; $display("FAIL bp_both_ready got=%0d exp=0", dual_viol); end
  endtask

  task automatic test_random();
    int n, r;
    for (int e = 0; e < 40; e++) begin
      expr_q.delete();
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        add_tok(r < 6 ? TK_OPERAND : (r < 8 ? TK_ADD : TK_MUL), 8'($urandom_range(0, 255)));
      end
      add_tok(TK_END, 8'($urandom_range(0, 255)));
      model_expr();
      run_expr($urandom_range(0, 3));
      checks++;
      if (obs_res !== exp_res || obs_ovf !== exp_ovf || obs_err !== exp_err) begin
        errors++;
        $display("FAIL rand_result expr=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", e, obs_res, obs_ovf, obs_err, exp_res, exp_ovf, exp_err);
      end
      checks++; if (!trace_matches()) begin errors++; $display("FAIL rand_trace expr=%0d got=%p exp=%p", e, trace, exp_ops); end
      checks++; if (obs_lat != exp_lat) begin errors++; $display("FAIL rand_latency expr=%0d got=%0d exp=%0d", e, obs_lat, exp_lat); end
      checks++; if (gap_viol != 0 || dual_viol != 0 || hold_viol != 0 || !obs_after)
        begin errors++; $display("FAIL rand_protocol expr=%0d gap=%0d dual=%0d hold=%0d after=%0b exp=0,0,0,1", e, gap_viol, dual_viol, hold_viol, obs_after); end
    end
  endtask

  task automatic test_reset_mid();
    hs_q.delete();
    send_token(TK_ADD, 8'd0);
    send_token(TK_OPERAND, 8'd100);
    send_token(TK_OPERAND, 8'd2);
    send_token(TK_MUL, 8'd0);
    send_token(TK_OPERAND, 8'd3);
    send_token(TK_OPERAND, 8'd4);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (res_error !== 1'b1 || res_overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_flags err=%0b ovf=%0b exp=1,1", res_error, res_overflow); end
    rst = 1'b1;
    #1;
    checks++;
    if (tok_ready !== 1'b0 || alu_opcode !== OP_NOP || alu_data !== 8'd0 || res_valid !== 1'b0 ||
        res_data !== 8'd0 || res_overflow !== 1'b0 || res_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs rdy=%0b op=%b data=%0d rv=%0b rd=%0d ovf=%0b err=%0b exp=0,000,0,0,0,0,0",
               tok_ready, alu_opcode, alu_data, res_valid, res_data, res_overflow, res_error);
    end
    #20;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL mid_release_tok_ready got=%0b exp=1", tok_ready); end
    expr_q.delete();
    add_tok(TK_OPERAND, 8'd6); add_tok(TK_OPERAND, 8'd7); add_tok(TK_ADD, 8'd0); add_tok(TK_END, 8'd0);
    run_expr(0);
    checks++; if (obs_res !== 8'd13 || obs_err !== 1'b0 || obs_ovf !== 1'b0)
      begin errors++; $display("FAIL mid_after_reset res=%0d err=%0b ovf=%0b exp=13,0,0", obs_res, obs_err, obs_ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_stack_full();
    test_empty_end();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
